// File: rtl/adc8_sampler.sv
// adc8_sampler: paces an external 8-bit parallel ADC, captures each result on
// the EOC falling edge, block-averages samples and raises overcurrent/timeout flags.
module adc8_sampler #(
    parameter int unsigned CONV_DIV    = 1000,
    parameter int unsigned CONVST_HIGH = 50,
    parameter int unsigned LOG2_N      = 3,
    parameter logic [7:0]  OC_LIMIT    = 8'd200,
    parameter int unsigned OC_COUNT    = 4
) (
    input  logic       i_CLK,
    input  logic       i_RST,
    input  logic       i_en,
    input  logic [7:0] i_adc_data,
    input  logic       i_eoc,
    output logic       o_convst,
    output logic [7:0] o_sample,
    output logic [7:0] o_avg,
    output logic       o_valid,
    output logic       o_oc,
    output logic       o_timeout
);
    localparam int unsigned ACC_W    = 8 + LOG2_N;
    localparam logic [15:0] LAST_CNT = 16'(CONV_DIV - 1);
    localparam logic [15:0] LAST_HI  = 16'(CONVST_HIGH - 1);
    localparam logic [6:0]  LAST_SMP = 7'((1 << LOG2_N) - 1);
    localparam logic [3:0]  OC_SAT   = 4'(OC_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CONVERT  = 2'd1,
        ST_WAIT_EOC = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [15:0]        r_cnt;
    logic [15:0]        r_hi_cnt;
    logic               r_eoc_s1;
    logic               r_eoc_s2;
    logic               r_eoc_prev;
    logic               w_eoc_fall;
    logic               w_capture;
    logic               w_timeout;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_sum;
    logic [6:0]         r_nsamp;
    logic [3:0]         r_streak;
    logic [3:0]         w_streak_nxt;
    logic               r_convst;
    logic [7:0]         r_sample;
    logic [7:0]         r_avg;
    logic               r_valid;
    logic               r_oc;
    logic               r_timeout;

    // EOC synchronizer plus a history flop; synced idle level is high
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_eoc_s1   <= 1'b1;
            r_eoc_s2   <= 1'b1;
            r_eoc_prev <= 1'b1;
        end else begin
            r_eoc_s1   <= i_eoc;
            r_eoc_s2   <= r_eoc_s1;
            r_eoc_prev <= r_eoc_s2;
        end
    end

    assign w_eoc_fall = r_eoc_prev & ~r_eoc_s2;

    // Conversion period counter, parked at zero while sampling is disabled
    always_ff @(posedge i_CLK) begin
        if (i_RST || !i_en) begin
            r_cnt <= 16'd0;
        end else if (r_cnt == LAST_CNT) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // State register, CONVST pulse width counter and registered CONVST
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_state  <= ST_IDLE;
            r_hi_cnt <= 16'd0;
            r_convst <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_hi_cnt <= (r_state == ST_CONVERT && w_state_nxt == ST_CONVERT) ?
                        r_hi_cnt + 16'd1 : 16'd0;
            r_convst <= (w_state_nxt == ST_CONVERT);
        end
    end

    // Next-state logic; a capture takes priority over the timeout in the last cycle
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        if (!i_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_cnt == 16'd0) w_state_nxt = ST_CONVERT;
                    else                w_state_nxt = ST_IDLE;
                end
                ST_CONVERT: begin
                    if (r_hi_cnt == LAST_HI) w_state_nxt = ST_WAIT_EOC;
                    else                     w_state_nxt = ST_CONVERT;
                end
                ST_WAIT_EOC: begin
                    if (w_eoc_fall) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end else if (r_cnt == LAST_CNT) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = ST_CONVERT;
                    end else begin
                        w_state_nxt = ST_WAIT_EOC;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == LAST_CNT) w_state_nxt = ST_CONVERT;
                    else                   w_state_nxt = ST_HOLD;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_sum        = r_acc + ACC_W'(i_adc_data);
    assign w_streak_nxt = (i_adc_data <= OC_LIMIT) ? 4'd0 :
                          (r_streak == OC_SAT)     ? r_streak : r_streak + 4'd1;

    // Sample capture, block averaging and the sticky fault flags
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_acc     <= '0;
            r_nsamp   <= 7'd0;
            r_streak  <= 4'd0;
            r_sample  <= 8'd0;
            r_avg     <= 8'd0;
            r_valid   <= 1'b0;
            r_oc      <= 1'b0;
            r_timeout <= 1'b0;
        end else if (!i_en) begin
            r_acc    <= '0;
            r_nsamp  <= 7'd0;
            r_streak <= 4'd0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_capture) begin
                r_sample <= i_adc_data;
                r_streak <= w_streak_nxt;
                if (w_streak_nxt == OC_SAT) begin
                    r_oc <= 1'b1;
                end
                if (r_nsamp == LAST_SMP) begin
                    r_avg   <= w_sum[LOG2_N +: 8];
                    r_acc   <= '0;
                    r_nsamp <= 7'd0;
                    r_valid <= 1'b1;
                end else begin
                    r_acc   <= w_sum;
                    r_nsamp <= r_nsamp + 7'd1;
                end
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign o_convst  = r_convst;
    assign o_sample  = r_sample;
    assign o_avg     = r_avg;
    assign o_valid   = r_valid;
    assign o_oc      = r_oc;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_adc8_sampler.sv
// Directed bench for adc8_sampler: a behavioural ADC answers each CONVST with
// an EOC fall after a programmable delay; all expectations are hand-computed.
module tb_adc8_sampler;
    logic       i_CLK = 1'b0;
    logic       i_RST = 1'b1;
    logic       i_en  = 1'b0;
    logic       i_eoc = 1'b1;
    logic [7:0] i_adc_data = 8'd0;
    logic       o_convst, o_valid, o_oc, o_timeout;
    logic [7:0] o_sample, o_avg;
    logic       z_convst, z_valid, z_oc, z_timeout;
    logic [7:0] z_sample, z_avg;

    int         n_total = 0;
    int         n_bad   = 0;
    int         cyc     = 0;
    logic [7:0] dtab [0:255];
    int         dptr     = 0;
    int         conv_idx = 0;
    int         skip_idx = -1;
    int         eoc_dly  = 200;
    logic [7:0] cur_data = 8'd0;
    int         v2_cnt   = 0;
    int         last_rise = 0;
    int         rise_per  = 0;
    int         hi_w      = 0;
    logic       mon_prev  = 1'b0;

    always #5 i_CLK = ~i_CLK;

    always @(posedge i_CLK) cyc <= cyc + 1;

    adc8_sampler dut (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_en(i_en), .i_adc_data(i_adc_data),
        .i_eoc(i_eoc), .o_convst(o_convst), .o_sample(o_sample), .o_avg(o_avg),
        .o_valid(o_valid), .o_oc(o_oc), .o_timeout(o_timeout)
    );

    adc8_sampler #(.LOG2_N(0)) dut_n1 (
        .i_CLK(i_CLK), .i_RST(i_RST), .i_en(i_en), .i_adc_data(i_adc_data),
        .i_eoc(i_eoc), .o_convst(z_convst), .o_sample(z_sample), .o_avg(z_avg),
        .o_valid(z_valid), .o_oc(z_oc), .o_timeout(z_timeout)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_CLK);
    endtask

    task automatic wait_rise(input string tag);
        int n;
        n = 0;
        while (o_convst && n < 2000) begin @(negedge i_CLK); n++; end
        while (!o_convst && n < 2000) begin @(negedge i_CLK); n++; end
        if (!o_convst) check({tag, "_tmo"}, 0, 1);
    endtask

    task automatic conv_done(input string tag);
        wait_rise(tag);
        tick(210);
    endtask

    task automatic wait_valid(input string tag, input int lim);
        int n;
        n = 0;
        while (!o_valid && n < lim) begin @(negedge i_CLK); n++; end
        check({tag, "_seen"}, int'(o_valid), 1);
    endtask

    task automatic put(input int i, input logic [7:0] v);
        dtab[(dptr + i) % 256] = v;
    endtask

    task automatic do_reset();
        i_en  = 1'b0;
        i_RST = 1'b1;
        tick(2);
        i_RST = 1'b0;
        tick(1);
    endtask

    // Behavioural ADC: EOC falls eoc_dly cycles after CONVST rises
    initial begin : adc_model
        bit abort;
        int dly;
        forever begin
            @(posedge o_convst);
            i_eoc = 1'b1;
            abort = 1'b0;
            dly   = eoc_dly;
            for (int k = 0; k < dly; k++) begin
                @(posedge i_CLK);
                if (i_RST || !i_en) begin
                    abort = 1'b1;
                    break;
                end
            end
            if (!abort && conv_idx != skip_idx) begin
                #1;
                i_adc_data = dtab[dptr % 256];
                cur_data   = dtab[dptr % 256];
                dptr       = dptr + 1;
                i_eoc      = 1'b0;
            end
            conv_idx = conv_idx + 1;
        end
    end

    // CONVST period/width tracking and per-capture check of the unaveraged instance
    always @(negedge i_CLK) begin
        if (o_convst && !mon_prev) begin
            rise_per  <= cyc - last_rise;
            last_rise <= cyc;
        end
        if (!o_convst && mon_prev) hi_w <= cyc - last_rise;
        mon_prev <= o_convst;
        if (z_valid) begin
            check("n1_avg", int'(z_avg), int'(cur_data));
            v2_cnt <= v2_cnt + 1;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got cycle %0d expected completion", cyc);
        $fatal(1, "bench stalled");
    end

    initial begin : main
        int t0;
        int v0;
        int n;
        for (int i = 0; i < 256; i++) dtab[i] = 8'd0;
        tick(3);
        check("rst_convst",  int'(o_convst),  0);
        check("rst_sample",  int'(o_sample),  0);
        check("rst_avg",     int'(o_avg),     0);
        check("rst_valid",   int'(o_valid),   0);
        check("rst_oc",      int'(o_oc),      0);
        check("rst_timeout", int'(o_timeout), 0);
        i_RST = 1'b0;
        tick(1);

        // constant 40 block, then 1..8 block
        for (int i = 0; i < 8; i++) put(i, 8'd40);
        for (int i = 0; i < 8; i++) put(8 + i, 8'(i + 1));
        v0   = v2_cnt;
        i_en = 1'b1;
        wait_rise("s1_first");
        t0 = cyc;
        wait_valid("s1_blk1", 9000);
        check("s1_latency", cyc - t0, 7202);
        check("s1_avg40",   int'(o_avg), 40);
        check("s1_sample",  int'(o_sample), 40);
        check("s1_period",  rise_per, 1000);
        check("s1_high",    hi_w, 50);
        t0 = cyc;
        tick(1);
        check("s1_vpulse1", int'(o_valid), 0);
        wait_valid("s1_blk2", 9000);
        check("s1_interval", cyc - t0, 8000);
        check("s1_avg_seq",  int'(o_avg), 4);
        tick(1);
        check("s1_vpulse2", int'(o_valid), 0);
        check("s1_n1_count", v2_cnt - v0, 16);
        i_en = 1'b0;
        tick(2);

        // overcurrent streak
        do_reset();
        put(0, 8'd201); put(1, 8'd201); put(2, 8'd201); put(3, 8'd150);
        put(4, 8'd201); put(5, 8'd201); put(6, 8'd201); put(7, 8'd201);
        put(8, 8'd0);
        i_en = 1'b1;
        for (int i = 0; i < 3; i++) conv_done("s2_a");
        check("s2_oc_after3", int'(o_oc), 0);
        conv_done("s2_b");
        check("s2_oc_break",   int'(o_oc), 0);
        check("s2_sample150",  int'(o_sample), 150);
        for (int i = 0; i < 3; i++) conv_done("s2_c");
        check("s2_oc_after3b", int'(o_oc), 0);
        conv_done("s2_d");
        check("s2_oc_trip", int'(o_oc), 1);
        conv_done("s2_e");
        check("s2_oc_sticky", int'(o_oc), 1);
        check("s2_sample0",   int'(o_sample), 0);
        i_en = 1'b0;
        tick(2);
        check("s2_oc_en_low", int'(o_oc), 1);
        i_RST = 1'b1;
        tick(1);
        check("s2_oc_rst", int'(o_oc), 0);
        i_RST = 1'b0;
        tick(1);

        // missing EOC on the third conversion
        do_reset();
        for (int i = 0; i < 8; i++) put(i, 8'd16);
        skip_idx = conv_idx + 2;
        i_en = 1'b1;
        wait_rise("s3_first");
        t0 = cyc;
        tick(210);
        conv_done("s3_c1");
        conv_done("s3_c2");
        check("s3_tmo_before", int'(o_timeout), 0);
        wait_rise("s3_retry");
        check("s3_tmo_set", int'(o_timeout), 1);
        wait_valid("s3_blk", 10000);
        check("s3_latency", cyc - t0, 8202);
        check("s3_avg",     int'(o_avg), 16);
        i_en = 1'b0;
        tick(2);

        // EOC strobe lands in the last cycle of the period
        do_reset();
        put(0, 8'd55); put(1, 8'd66);
        i_en = 1'b1;
        conv_done("s4_c0");
        check("s4_sample55", int'(o_sample), 55);
        eoc_dly = 997;
        wait_rise("s4_c1");
        n = 0;
        while (o_sample != 8'd66 && n < 1100) begin @(negedge i_CLK); n++; end
        check("s4_late_capture", int'(o_sample), 66);
        check("s4_no_timeout",   int'(o_timeout), 0);
        i_en    = 1'b0;
        eoc_dly = 200;
        tick(2);

        // enable dropped mid-conversion after five samples
        do_reset();
        for (int i = 0; i < 5; i++) put(i, 8'd100);
        for (int i = 0; i < 8; i++) put(5 + i, 8'd10);
        i_en = 1'b1;
        for (int i = 0; i < 5; i++) conv_done("s5_a");
        check("s5_sample100", int'(o_sample), 100);
        wait_rise("s5_c5");
        tick(10);
        i_en = 1'b0;
        tick(1);
        check("s5_convst_off", int'(o_convst), 0);
        check("s5_sample_held", int'(o_sample), 100);
        tick(20);
        i_en = 1'b1;
        wait_valid("s5_blk", 9000);
        check("s5_avg_fresh", int'(o_avg), 10);

        // reset during CONVERT with enable still high
        wait_rise("s6_conv");
        tick(5);
        i_RST = 1'b1;
        tick(1);
        check("s6_convst", int'(o_convst), 0);
        check("s6_sample", int'(o_sample), 0);
        check("s6_avg",    int'(o_avg), 0);
        check("s6_valid",  int'(o_valid), 0);
        i_RST = 1'b0;
        tick(1);
        check("s6_restart", int'(o_convst), 1);
        i_en = 1'b0;
        tick(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/adc8_sampler.md
ADC8_SAMPLER -- requirements
Module: adc8_sampler

Interface
REQ-001 Parameter CONV_DIV, default 1000: conversion period in i_CLK cycles (100 kHz at 100 MHz); legal 16..65535.
REQ-002 Parameter CONVST_HIGH, default 50: o_convst high time in cycles; legal 1..CONV_DIV/2.
REQ-003 Parameter LOG2_N, default 3: block average over 2^LOG2_N samples; legal 0..6.
REQ-004 Parameter OC_LIMIT, default 8'd200: overcurrent raw threshold (strictly greater trips).
REQ-005 Parameter OC_COUNT, default 4: consecutive over-limit samples to latch o_oc; legal 1..15.
REQ-006 i_CLK  input  1  system clock; one clock, all logic on posedge.
REQ-007 i_RST  input  1  reset, synchronous, active-high.
REQ-008 i_en  input  1  sampling enable (level).
REQ-009 i_adc_data  input  8  parallel ADC result, stable from EOC falling edge until next CONVST.
REQ-010 i_eoc  input  1  ADC end-of-conversion, asynchronous to i_CLK, active-low completion edge.
REQ-011 o_convst  output  1  ADC conversion start, registered.
REQ-012 o_sample  output  8  last captured raw sample.
REQ-013 o_avg  output  8  last completed block average.
REQ-014 o_valid  output  1  one-cycle pulse when o_avg updates.
REQ-015 o_oc  output  1  sticky overcurrent fault.
REQ-016 o_timeout  output  1  sticky missing-EOC flag.

Function
REQ-017 i_eoc SHALL pass a 2-flop synchronizer; fall strobe = previous synced value 1 and current 0.
REQ-018 Period counter SHALL count 0..CONV_DIV-1 and wrap while i_en=1; held at 0 while i_en=0.
REQ-019 FSM states SHALL be IDLE, CONVERT, WAIT_EOC, HOLD.
REQ-020 IDLE: o_convst=0; on i_en=1 go to CONVERT at the edge where period counter is 0.
REQ-021 CONVERT: o_convst=1 for exactly CONVST_HIGH cycles, then WAIT_EOC with o_convst=0.
REQ-022 WAIT_EOC: on fall strobe, at that clock edge o_sample<=i_adc_data, accumulate, go HOLD.
REQ-023 WAIT_EOC with period counter at CONV_DIV-1 and no fall strobe: set o_timeout, discard period (no accumulate, o_oc streak unchanged), go CONVERT.
REQ-024 HOLD: ignore further strobes; at period counter CONV_DIV-1 go CONVERT.
REQ-025 Fall strobes outside WAIT_EOC SHALL be ignored.
REQ-026 Accumulator width SHALL be 8+LOG2_N bits, no overflow possible.
REQ-027 On capture of the 2^LOG2_N-th sample, o_avg<=(acc+sample)>>LOG2_N (truncating), accumulator and sample count cleared in same edge, o_valid=1 the following cycle only.
REQ-028 LOG2_N=0: o_avg equals every captured sample, o_valid pulses each capture.
REQ-029 Over-limit streak counter SHALL increment on each capture with sample>OC_LIMIT, clear on capture with sample<=OC_LIMIT, saturate at OC_COUNT; o_oc set when streak reaches OC_COUNT.
REQ-030 o_oc, o_timeout SHALL clear only on i_RST.
REQ-031 i_en falling mid-operation: next edge go IDLE, o_convst=0, accumulator, sample count, streak cleared; o_sample, o_avg, sticky flags held.
REQ-032 Simultaneous fall strobe and timeout cycle in WAIT_EOC: capture wins, no timeout.

Reset
REQ-033 On i_RST: FSM IDLE, period counter 0, synchronizer flops 1, all outputs 0, accumulator, sample count, streak 0.
REQ-034 Reset SHALL override i_en and any in-flight conversion at the same edge.

Verification
REQ-035 Defaults, ADC model EOC low 200 cycles after CONVST rise, data 8'd40 constant -> o_convst period 1000, high 50; o_valid every 8000 cycles; o_avg=40.
REQ-036 Data sequence 1,2,...,8 -> o_avg=4 (36>>3), o_valid single cycle, next block starts from zero.
REQ-037 Data 201 for 3 samples then 150, then 201 x4 -> o_oc asserts on 4th consecutive 201 only; stays high after data returns to 0 until i_RST.
REQ-038 ADC model suppresses EOC for one period -> o_timeout=1 at counter 999, that sample not averaged, next o_valid delayed one period.
REQ-039 i_en dropped after 5 samples, re-raised -> o_convst low within 1 cycle, next o_avg from 8 fresh samples only.
REQ-040 i_RST asserted during CONVERT -> o_convst 0 next edge, all outputs 0, restart clean at counter 0.
